// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem request, 2-entry {pc, inst, fault} queue, redirect flush.
// Optional misaligned-redirect fault entry when IFU_MISALIGN_CHK_EN is defined.
module ifu_fetch #(
  parameter int              PC_W     = 64,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_fault
);

  // Both channels transfer on a cycle where valid && ready; valid never waits on ready.
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_HALT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PC_W-1:0]   fetch_pc;
  logic [PC_W-1:0]   q_pc [2];
  logic [INST_W-1:0] q_inst [2];
  logic [1:0]        count;

  logic req_fire;
  logic pop;
  logic push;
  logic wr_slot;
  logic outstanding_after;

`ifdef IFU_MISALIGN_CHK_EN
  logic [1:0] q_fault;
  logic       misalign;
  assign misalign = (redirect_pc[1:0] != 2'b00);
`endif

  assign req_fire = imem_req_valid && imem_req_ready;
  assign pop      = out_valid && out_ready;
  assign push     = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;
  // Slot index after a same-cycle pop has shifted the queue down.
  assign wr_slot  = (count == 2'd2) || ((count == 2'd1) && !pop);
  // A request is still in flight after this edge, so its response must be swallowed.
  assign outstanding_after = ((state == S_REQ) && req_fire) ||
                             (((state == S_WAIT) || (state == S_DRAIN)) && !imem_rsp_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      if (outstanding_after) state_nxt = S_DRAIN;
      else                   state_nxt = S_REQ;
`ifdef IFU_MISALIGN_CHK_EN
      if (misalign) state_nxt = S_HALT;
`endif
    end else begin
      case (state)
        S_IDLE:          state_nxt = S_REQ;
        S_REQ:           if (req_fire) state_nxt = S_WAIT;
        S_WAIT, S_DRAIN: if (imem_rsp_valid) state_nxt = S_REQ;
        default:         state_nxt = state;
      endcase
    end
  end

  always_comb begin
    imem_req_valid = (state == S_REQ) && (count != 2'd2);
    imem_req_addr  = fetch_pc;
    out_valid      = (count != 2'd0);
    out_pc         = q_pc[0];
    out_inst       = q_inst[0];
`ifdef IFU_MISALIGN_CHK_EN
    out_fault      = q_fault[0];
`else
    out_fault      = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      count     <= 2'd0;
      q_pc[0]   <= '0;
      q_pc[1]   <= '0;
      q_inst[0] <= '0;
      q_inst[1] <= '0;
`ifdef IFU_MISALIGN_CHK_EN
      q_fault   <= 2'b00;
`endif
    end else if (redirect_valid) begin
      count <= 2'd0;
`ifdef IFU_MISALIGN_CHK_EN
      fetch_pc <= redirect_pc;
      if (misalign) begin
        q_pc[0]    <= redirect_pc;
        q_inst[0]  <= '0;
        q_fault[0] <= 1'b1;
        count      <= 2'd1;
      end
`else
      fetch_pc <= redirect_pc & ~PC_W'(3);
`endif
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + PC_W'(4);
      if (pop) begin
        q_pc[0]    <= q_pc[1];
        q_inst[0]  <= q_inst[1];
`ifdef IFU_MISALIGN_CHK_EN
        q_fault[0] <= q_fault[1];
`endif
      end
      // fetch_pc already advanced past the outstanding request.
      if (push) begin
        q_pc[wr_slot]    <= fetch_pc - PC_W'(4);
        q_inst[wr_slot]  <= imem_rsp_data;
`ifdef IFU_MISALIGN_CHK_EN
        q_fault[wr_slot] <= 1'b0;
`endif
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: transaction-level model of the fetch stream, randomized memory and core.
module tb_ifu_fetch;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        out_fault;

  ifu_fetch dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_fault(out_fault)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: entries {fault, pc, inst} the core should see, in order
  logic [96:0] exp_q[$];
  logic [63:0] exp_req_pc;
  logic [63:0] m_req_pc;
  bit          m_idle, m_out, m_live, m_halt;

  // memory model
  bit          mem_pend;
  int          mem_delay;
  logic [63:0] mem_addr;
  bit          s_fire;
  logic [63:0] s_addr;

  // knobs
  int          p_ready, max_lat, p_out_ready, p_redir;
  int          redir_mode;
  logic [63:0] redir_pc_f;
  int          rst_cycles;
  bit          stale_inject;

  int cyc, n_checks, n_fail, pop_cnt, last_pop;
  bit thru_chk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ {a[15:0], a[31:16]} ^ 32'h5a5a_a5a5;
  endfunction

  task automatic check(input string tag, input logic [96:0] got, input logic [96:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic sample_and_model();
    bit fire, rsp, pop, rd, exp_rv;
    if (rst) begin
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_req_addr", imem_req_addr, RESET_PC);
      check("rst_out", {out_valid, out_fault, out_pc, out_inst}, 0);
      exp_q.delete();
      m_idle = 1; m_out = 0; m_live = 0; m_halt = 0;
      exp_req_pc = RESET_PC;
      s_fire = 0;
      return;
    end
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("out_entry", {out_fault, out_pc, out_inst}, exp_q[0]);
    exp_rv = !m_idle && !m_out && !m_halt && (exp_q.size() < 2);
    check("req_valid", imem_req_valid, exp_rv);
    if (imem_req_valid) check("req_addr", imem_req_addr, exp_req_pc);

    fire = imem_req_valid && imem_req_ready;
    rsp  = imem_rsp_valid;
    pop  = out_valid && out_ready;
    rd   = redirect_valid;
    s_fire = fire;
    s_addr = imem_req_addr;
    m_idle = 0;

    if (pop && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      pop_cnt++;
      if (thru_chk && last_pop >= 0) check("thru_gap", cyc - last_pop, 2);
      last_pop = cyc;
    end
    if (rd) begin
      exp_q.delete();
      if (fire) begin m_out = 1; m_live = 0; end
      else if (m_out && !rsp) m_live = 0;
      else m_out = 0;
`ifdef IFU_MISALIGN_CHK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        m_halt = 1;
        exp_q.push_back({1'b1, redirect_pc, 32'h0});
      end else begin
        m_halt = 0;
        exp_req_pc = redirect_pc;
      end
`else
      m_halt = 0;
      exp_req_pc = {redirect_pc[63:2], 2'b00};
`endif
    end else begin
      if (rsp && m_out) begin
        if (m_live) exp_q.push_back({1'b0, m_req_pc, mem_word(m_req_pc)});
        m_out = 0;
      end
      if (fire) begin
        m_out = 1; m_live = 1;
        m_req_pc = exp_req_pc;
        exp_req_pc = exp_req_pc + 64'd4;
      end
    end
  endtask

  // driver: memory responder, core stimulus, reset control
  task automatic drive();
    int unsigned off;
    bit go;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_cycles > 0) begin rst = 1; rst_cycles--; end
    else rst = 0;
    imem_rsp_valid = 0;
    if (!rst) begin
      if (stale_inject) begin
        imem_rsp_valid = 1;
        imem_rsp_data  = 32'hbad0_bad0;
        stale_inject = 0;
        mem_pend = 0;
      end else begin
        if (s_fire) begin
          mem_pend = 1;
          mem_addr = s_addr;
          mem_delay = $urandom_range(max_lat, 0);
        end
        if (mem_pend) begin
          if (mem_delay == 0) begin
            imem_rsp_valid = 1;
            imem_rsp_data  = mem_word(mem_addr);
            mem_pend = 0;
          end else mem_delay--;
        end
      end
    end
    imem_req_ready = ($urandom_range(99, 0) < p_ready);
    out_ready      = ($urandom_range(99, 0) < p_out_ready);
    redirect_valid = 0;
    go = 0;
    case (redir_mode)
      1: go = 1;
      2: go = mem_pend && (mem_delay == 0) && !imem_rsp_valid;
      3: go = imem_rsp_valid;
      default: go = 0;
    endcase
    if (rst) go = 0;
    if (go) begin
      redirect_valid = 1;
      redirect_pc = redir_pc_f;
      redir_mode = 0;
    end else if (!rst && $urandom_range(99, 0) < p_redir) begin
      off = $urandom_range(1023, 0);
`ifdef IFU_MISALIGN_CHK_EN
      off = off & ~32'd3;
`endif
      redirect_valid = 1;
      redirect_pc = 64'h8000_0000 + 64'(off);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    sample_and_model();
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic redirect_at(input int mode, input logic [63:0] pc);
    int k;
    redir_mode = mode;
    redir_pc_f = pc;
    k = 0;
    while (redir_mode != 0 && k < 100) begin cycle(); k++; end
    check("redir_timeout", redir_mode, 0);
    redir_mode = 0;
  endtask

  initial begin
    int k;
    rst = 1; rst_cycles = 2;
    redirect_valid = 0; redirect_pc = 0;
    imem_req_ready = 1; imem_rsp_valid = 0; imem_rsp_data = 0; out_ready = 1;
    mem_pend = 0; mem_delay = 0; mem_addr = 0; s_fire = 0; s_addr = 0;
    stale_inject = 0; redir_mode = 0; redir_pc_f = 0;
    cyc = 0; n_checks = 0; n_fail = 0; pop_cnt = 0; last_pop = -1;
    exp_req_pc = RESET_PC; m_req_pc = 0;
    m_idle = 1; m_out = 0; m_live = 0; m_halt = 0;

    // streaming at peak rate: one instruction every 2 cycles
    p_ready = 100; max_lat = 0; p_out_ready = 100; p_redir = 0;
    thru_chk = 1;
    run(24);
    thru_chk = 0;
    check("stream_pops", pop_cnt >= 8, 1);

    // core stalls: queue fills, requests stop, then drain and resume
    p_out_ready = 0;
    run(10);
    check("stall_out_valid", out_valid, 1);
    check("stall_req_valid", imem_req_valid, 0);
    p_out_ready = 100;
    run(10);

    // redirect in WAIT, response one cycle later is discarded
    max_lat = 1;
    redirect_at(2, 64'h8000_0100);
    run(10);

    // redirect in the same cycle as a response
    max_lat = 0;
    redirect_at(3, 64'h8000_0200);
    run(10);

    // misaligned redirect
    p_ready = 0;
    run(6);
    p_out_ready = 0;
    redirect_at(1, 64'h8000_0102);
    p_ready = 100;
    run(5);
`ifdef IFU_MISALIGN_CHK_EN
    check("mis_fault", {out_valid, out_fault, out_pc}, {1'b1, 1'b1, 64'h8000_0102});
    check("mis_no_req", imem_req_valid, 0);
`else
    check("mis_aligned_fetch", {out_valid, out_fault, out_pc}, {1'b1, 1'b0, 64'h8000_0100});
`endif
    p_out_ready = 100;
    redirect_at(1, 64'h8000_0000);
    run(10);

    // reset pulse while a response is pending; the late response must be ignored
    max_lat = 3;
    k = 0;
    while (!(mem_pend && mem_delay >= 1) && k < 200) begin cycle(); k++; end
    check("wait_found", mem_pend && mem_delay >= 1, 1);
    rst = 1; rst_cycles = 1; stale_inject = 1;
    run(15);

    // randomized traffic
    p_ready = 70; max_lat = 3; p_out_ready = 60; p_redir = 5;
    run(2000);
    p_redir = 0;
    run(20);
    check("liveness", pop_cnt > 200, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
